// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extender with valid/ready handshake.
// A main output register and a skid register let it absorb two items
// while execute is stalled. Illegal modes produce zero data with out_err set.
module imm_ext_pipe #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic             err_sticky
);

    // Out-of-range parameters stop elaboration rather than build a broken datapath.
    if (IN_W < 2 || IN_W > OUT_W) begin : g_bad_in_w
        $error("imm_ext_pipe: IN_W must satisfy 2 <= IN_W <= OUT_W");
    end
    if (OUT_W < IN_W + 2) begin : g_bad_out_w
        $error("imm_ext_pipe: OUT_W must be at least IN_W + 2");
    end
    if (SHAMT_W < 1 || SHAMT_W > IN_W) begin : g_bad_shamt_w
        $error("imm_ext_pipe: SHAMT_W must satisfy 1 <= SHAMT_W <= IN_W");
    end

    typedef enum logic [2:0] {
        MODE_ZERO   = 3'd0,
        MODE_SIGN   = 3'd1,
        MODE_UPPER  = 3'd2,
        MODE_SHAMT  = 3'd3,
        MODE_BRANCH = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int PAD_W = OUT_W - IN_W;

    mode_e             mode;
    logic [OUT_W-1:0]  sign_ext;
    logic [OUT_W-1:0]  ext_data;
    logic              ext_err;

    state_e            state, state_next;
    logic              accept, deliver;
    logic              load_main_in, load_main_skid, load_skid;
    logic [OUT_W-1:0]  main_data, skid_data;
    logic              main_err, skid_err;

    assign mode     = mode_e'(in_mode);
    assign sign_ext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};

    // Extension is done before capture so the registers hold final results.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned (which infers a latch).
        ext_data = '0;
        ext_err  = 1'b0;
        case (mode)
            MODE_ZERO:   ext_data = {{PAD_W{1'b0}}, in_imm};
            MODE_SIGN:   ext_data = sign_ext;
            MODE_UPPER:  ext_data = {in_imm, {PAD_W{1'b0}}};
            MODE_SHAMT:  ext_data = {{(OUT_W-SHAMT_W){1'b0}}, in_imm[SHAMT_W-1:0]};
            MODE_BRANCH: ext_data = {sign_ext[OUT_W-3:0], 2'b00};
            default:     ext_err  = 1'b1;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign out_valid = (state != ST_EMPTY);
    assign deliver   = out_valid & out_ready;
    assign out_data  = main_data;
    assign out_err   = main_err;

    // Item-count state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_next;
    end

    // Next-state and register-load decode; flush overrides all handshakes.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next   = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_next = ST_FULL;
                        load_skid  = 1'b1;
                    end else if (deliver) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (deliver) begin
                        state_next     = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // Main and skid data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data registers are reset because out_data must read zero
        // during reset; storage with no such visible reset value would not be.
        if (!rst_n) begin
            main_data <= '0;
            main_err  <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_data <= ext_data;
                main_err  <= ext_err;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_err  <= skid_err;
            end
            if (load_skid) begin
                skid_data <= ext_data;
                skid_err  <= ext_err;
            end
        end
    end

    // in_ready comes straight from a flop: low exactly while skid is occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready <= 1'b1;
        else        in_ready <= (state_next != ST_FULL);
    end

    // Sticky error: any accepted illegal item, flush cycle included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  err_sticky <= 1'b0;
        else if (accept && ext_err)  err_sticky <= 1'b1;
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Testbench for imm_ext_pipe: vector table for the modes, scoreboard queue
// for ordering, and hand sequences for backpressure, flush and reset.
module tb_imm_ext_pipe;

    localparam int IN_W    = 16;
    localparam int OUT_W   = 32;
    localparam int SHAMT_W = 5;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic [15:0] imm;
        logic [2:0]  mode;
        logic [31:0] data;
        logic        err;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;
    logic             err_sticky;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_dlv   = 0;
    logic exp_sticky = 1'b0;
    exp_t sb[$];
    vec_t vecs[6];

    imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT_W(SHAMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference extension written arithmetically, independent of the RTL.
    function automatic exp_t model(input logic [15:0] imm, input logic [2:0] mode);
        exp_t        e;
        logic signed [31:0] s;
        s      = $signed(imm);
        e.err  = 1'b0;
        e.data = 32'h0;
        case (mode)
            3'd0:    e.data = 32'(imm);
            3'd1:    e.data = s;
            3'd2:    e.data = 32'(imm) << 16;
            3'd3:    e.data = 32'(imm) & 32'h1F;
            3'd4:    e.data = s <<< 2;
            default: e.err  = 1'b1;
        endcase
        return e;
    endfunction

    // One clock: predict handshakes from current signals, take the edge,
    // then settle 1 time unit past it. Scoreboard push/pop happens here.
    task automatic step();
        logic acc, dlv;
        exp_t e, got;
        acc = in_valid & in_ready;
        dlv = out_valid & out_ready;
        e   = model(in_imm, in_mode);
        if (acc && e.err) exp_sticky = 1'b1;
        if (flush) begin
            sb.delete();
        end else begin
            if (dlv) begin
                n_dlv++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got 0x%0h with empty scoreboard", out_data);
                end else begin
                    got = sb.pop_front();
                    check("sb_data", out_data, got.data);
                    check("sb_err", out_err, got.err);
                end
            end
            if (acc) sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check("sticky", err_sticky, exp_sticky);
    endtask

    initial begin
        vecs[0] = '{16'h8001, 3'd0, 32'h0000_8001, 1'b0};
        vecs[1] = '{16'h8001, 3'd1, 32'hFFFF_8001, 1'b0};
        vecs[2] = '{16'h1234, 3'd2, 32'h1234_0000, 1'b0};
        vecs[3] = '{16'hFFFF, 3'd3, 32'h0000_001F, 1'b0};
        vecs[4] = '{16'hFFFF, 3'd4, 32'hFFFF_FFFC, 1'b0};
        vecs[5] = '{16'hABCD, 3'd6, 32'h0000_0000, 1'b1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_err", out_err, 0);
        check("rst_sticky", err_sticky, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Mode table: accept, check one cycle later, then deliver.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_imm = vecs[i].imm; in_mode = vecs[i].mode; out_ready = 1'b0;
            step();
            in_valid = 1'b0;
            check("vec_valid", out_valid, 1);
            check("vec_data", out_data, vecs[i].data);
            check("vec_err", out_err, vecs[i].err);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        check("sticky_after_illegal", err_sticky, 1);

        // Backpressure: A,B absorbed, C held off until the first delivery.
        in_valid = 1'b1; in_mode = 3'd0;
        in_imm = 16'h00A0; step();
        check("bp_ready_after_a", in_ready, 1);
        in_imm = 16'h00B0; step();
        check("bp_ready_after_b", in_ready, 0);
        in_imm = 16'h00C0; step();
        check("bp_ready_held", in_ready, 0);
        check("bp_hold_data", out_data, 32'h0000_00A0);
        out_ready = 1'b1;
        step();
        check("bp_ready_rise", in_ready, 1);
        check("bp_valid_b", out_valid, 1);
        step();
        in_valid = 1'b0;
        check("bp_valid_c", out_valid, 1);
        check("bp_data_c", out_data, 32'h0000_00C0);
        step();
        check("bp_drained", out_valid, 0);
        check("bp_sb_empty", sb.size(), 0);

        // Streaming: 8 back-to-back items, in_ready never drops.
        begin
            int d0;
            d0 = n_dlv;
            out_ready = 1'b1;
            for (int i = 0; i < 8; i++) begin
                in_valid = 1'b1;
                in_imm   = 16'($urandom);
                in_mode  = 3'($urandom_range(0, 4));
                check("stream_ready", in_ready, 1);
                if (i > 0) check("stream_valid", out_valid, 1);
                step();
            end
            in_valid = 1'b0;
            step();
            check("stream_count", n_dlv - d0, 8);
            check("stream_empty", out_valid, 0);
        end

        // Flush with FULL and C offered: nothing is delivered afterwards.
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd1;
        in_imm = 16'h1111; step();
        in_imm = 16'h2222; step();
        check("fl_full", in_ready, 0);
        in_imm = 16'h3333; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        begin
            int d0;
            d0 = n_dlv;
            out_ready = 1'b1;
            repeat (3) step();
            check("fl_no_dlv", n_dlv - d0, 0);
        end
        check("fl_sticky_kept", err_sticky, 1);

        // Reset mid-stream between edges.
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd0;
        in_imm = 16'h0101; step();
        in_imm = 16'h0202; step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mr_valid", out_valid, 0);
        check("mr_data", out_data, 0);
        check("mr_sticky", err_sticky, 0);
        check("mr_ready", in_ready, 1);
        sb.delete();
        exp_sticky = 1'b0;
        #1 rst_n = 1'b1;
        begin
            int d0;
            d0 = n_dlv;
            in_valid = 1'b1; in_imm = 16'h0D0D; in_mode = 3'd0;
            step();
            in_valid = 1'b0; out_ready = 1'b1;
            check("mr_new_data", out_data, 32'h0000_0D0D);
            repeat (3) step();
            check("mr_single_dlv", n_dlv - d0, 1);
        end
        check("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
